// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch predictor / resolver pair.
// Record PCs are stored at the maximum supported width (64); the resolver's
// XLEN parameter may be narrower and is cast at the boundary.
package branch_pkg;

  localparam int unsigned PC_MAX_W    = 64;
  localparam int unsigned BTB_INDEX_W = 10;
  localparam int unsigned BTB_TAG_W   = 54;
  localparam int unsigned PC_STEP     = 4;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic                pred_taken;
    logic                pred_miss;
    logic [PC_MAX_W-1:0] pred_target;
  } pred_rec_t;

endpackage

// File: rtl/branch_resolver_pred_queue.sv
// branch_pred_queue: circular FIFO of prediction records with flush.
// Pointers carry one extra wrap bit; full/empty are registered from the
// next-state pointers so they are valid right after the updating edge.
module branch_pred_queue
  import branch_pkg::*;
#(
  parameter int unsigned QDEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  pred_rec_t din,
  output pred_rec_t head,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned PW = AW + 1;

  pred_rec_t     mem [QDEPTH];
  logic [PW-1:0] wptr, rptr, wptr_n, rptr_n;
  logic          do_push, do_pop;

  // Pointer next-state: a pop frees a slot for a same-cycle push; flush wins.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop) && !flush;
    wptr_n  = wptr;
    rptr_n  = rptr;
    if (flush) begin
      wptr_n = '0;
      rptr_n = '0;
    end else begin
      if (do_push) wptr_n = wptr + PW'(1);
      if (do_pop)  rptr_n = rptr + PW'(1);
    end
  end

  // Pointer and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      full  <= (wptr_n == {~rptr_n[AW], rptr_n[AW-1:0]});
      empty <= (wptr_n == rptr_n);
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

  assign head = mem[rptr[AW-1:0]];

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: checks queued predictions against resolved outcomes and
// emits BTB allocate / counter update / redirect strobes.
// Optional statistics counters: define BRANCH_RESOLVER_STATS_EN.
// XLEN must not exceed 64.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int unsigned QDEPTH = 8,
  parameter int unsigned XLEN   = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_fetch_valid,
  input  logic [XLEN-1:0] in_fetch_pc,
  input  logic            in_pred_taken,
  input  logic            in_pred_miss,
  input  logic [XLEN-1:0] in_pred_target,
  input  logic            in_resolve_valid,
  input  logic [XLEN-1:0] in_resolve_pc,
  input  logic            in_is_branch,
  input  logic            in_actual_taken,
  input  logic [XLEN-1:0] in_actual_target,
  input  logic            in_stall_from_icache,
  input  logic            in_stall_from_dcache,
  input  logic            in_stall_from_hazardunit,
  output logic            out_write_to_bp,
  output logic [XLEN-1:0] out_branch_source,
  output logic [XLEN-1:0] out_branch_target,
  output logic            out_is_update_state,
  output logic [XLEN-1:0] out_source,
  output logic            out_is_actual_branch_taken,
  output logic            out_redirect,
  output logic [XLEN-1:0] out_redirect_pc,
  output logic            out_full,
  output logic            out_empty,
  output logic            out_sync_error,
  output logic [31:0]     out_branch_count,
  output logic [31:0]     out_mispredict_count
);

  logic            stall;
  pred_rec_t       rec_in, head;
  logic [XLEN-1:0] head_pc, head_tgt, head_pc4;
  logic            hit, sync_err_n;
  logic            wbp_n, upd_n, redir_n;
  logic [XLEN-1:0] redir_pc_n;

  assign stall    = in_stall_from_icache | in_stall_from_dcache | in_stall_from_hazardunit;
  assign rec_in   = '{pc:          PC_MAX_W'(in_fetch_pc),
                      pred_taken:  in_pred_taken,
                      pred_miss:   in_pred_miss,
                      pred_target: PC_MAX_W'(in_pred_target)};
  assign head_pc  = XLEN'(head.pc);
  assign head_tgt = XLEN'(head.pred_target);
  assign head_pc4 = head_pc + XLEN'(PC_STEP);

  branch_pred_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (in_fetch_valid && !stall),
    .pop   (in_resolve_valid && !stall),
    .flush (redir_n && !stall),
    .din   (rec_in),
    .head  (head),
    .full  (out_full),
    .empty (out_empty)
  );

  // Compare the head record with the resolve and decide the strobes.
  always_comb begin
    wbp_n      = 1'b0;
    upd_n      = 1'b0;
    redir_n    = 1'b0;
    redir_pc_n = head_pc4;
    hit        = in_resolve_valid && !out_empty && (head_pc == in_resolve_pc);
    sync_err_n = (in_resolve_valid && !hit) ||
                 (in_fetch_valid && out_full && !in_resolve_valid);
    if (hit) begin
      if (!in_is_branch) begin
        redir_n = head.pred_taken;
      end else if (head.pred_miss) begin
        if (in_actual_taken) begin
          wbp_n      = 1'b1;
          redir_n    = 1'b1;
          redir_pc_n = in_actual_target;
        end
      end else begin
        upd_n = 1'b1;
        if (head.pred_taken != in_actual_taken) begin
          redir_n    = 1'b1;
          redir_pc_n = in_actual_taken ? in_actual_target : head_pc4;
        end else if (in_actual_taken && (head_tgt != in_actual_target)) begin
          wbp_n      = 1'b1;
          redir_n    = 1'b1;
          redir_pc_n = in_actual_target;
        end
      end
    end
  end

  // Output registers; everything holds while stalled so pending strobes persist.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_write_to_bp            <= 1'b0;
      out_branch_source          <= '0;
      out_branch_target          <= '0;
      out_is_update_state        <= 1'b0;
      out_source                 <= '0;
      out_is_actual_branch_taken <= 1'b0;
      out_redirect               <= 1'b0;
      out_redirect_pc            <= '0;
      out_sync_error             <= 1'b0;
    end else if (!stall) begin
      out_write_to_bp     <= wbp_n;
      out_is_update_state <= upd_n;
      out_redirect        <= redir_n;
      if (wbp_n) begin
        out_branch_source <= head_pc;
        out_branch_target <= in_actual_target;
      end
      if (upd_n) begin
        out_source                 <= head_pc;
        out_is_actual_branch_taken <= in_actual_taken;
      end
      if (redir_n)    out_redirect_pc <= redir_pc_n;
      if (sync_err_n) out_sync_error  <= 1'b1;
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  // Saturating branch and mispredict statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_branch_count     <= '0;
      out_mispredict_count <= '0;
    end else if (!stall) begin
      if (hit && in_is_branch && (out_branch_count != '1))
        out_branch_count <= out_branch_count + 32'd1;
      if (redir_n && (out_mispredict_count != '1))
        out_mispredict_count <= out_mispredict_count + 32'd1;
    end
  end
`else
  assign out_branch_count     = '0;
  assign out_mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a queue-based reference model
// predicts every post-edge output set; a monitor pops and compares.
module tb_branch_resolver;

  localparam int unsigned QDEPTH = 8;
  localparam int unsigned XLEN   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, fetch_valid, pred_taken, pred_miss;
  logic [XLEN-1:0] fetch_pc, pred_target, resolve_pc, actual_target;
  logic            resolve_valid, is_branch, actual_taken;
  logic            st_i, st_d, st_h;
  logic            wbp, upd, act_dir, redir, full, empty, sync_err;
  logic [XLEN-1:0] bsrc, btgt, src, rpc;
  logic [31:0]     bcnt, mcnt;

  branch_resolver #(.QDEPTH(QDEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .in_fetch_valid(fetch_valid), .in_fetch_pc(fetch_pc),
    .in_pred_taken(pred_taken), .in_pred_miss(pred_miss), .in_pred_target(pred_target),
    .in_resolve_valid(resolve_valid), .in_resolve_pc(resolve_pc),
    .in_is_branch(is_branch), .in_actual_taken(actual_taken), .in_actual_target(actual_target),
    .in_stall_from_icache(st_i), .in_stall_from_dcache(st_d), .in_stall_from_hazardunit(st_h),
    .out_write_to_bp(wbp), .out_branch_source(bsrc), .out_branch_target(btgt),
    .out_is_update_state(upd), .out_source(src), .out_is_actual_branch_taken(act_dir),
    .out_redirect(redir), .out_redirect_pc(rpc),
    .out_full(full), .out_empty(empty), .out_sync_error(sync_err),
    .out_branch_count(bcnt), .out_mispredict_count(mcnt)
  );

  typedef struct {
    logic [63:0] pc;
    logic        pt;
    logic        pm;
    logic [63:0] tgt;
  } mrec_t;

  typedef struct {
    logic        wbp;
    logic [63:0] bsrc;
    logic [63:0] btgt;
    logic        upd;
    logic [63:0] src;
    logic        dir;
    logic        redir;
    logic [63:0] rpc;
    logic        full;
    logic        empty;
    logic        err;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  mrec_t mq[$];
  exp_t  m;
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Reference model: applies one clock edge worth of the branch rules.
  task automatic model_step();
    logic        stall, hit, rd;
    logic [63:0] npc;
    mrec_t       h;
    exp_t        e;
    stall = st_i | st_d | st_h;
    hit   = 1'b0;
    rd    = 1'b0;
    npc   = '0;
    h     = '{default: 0};
    if (reset) begin
      mq.delete();
      m       = '{default: 0};
      m.empty = 1'b1;
    end else if (!stall) begin
      m.wbp = 1'b0; m.upd = 1'b0; m.redir = 1'b0;
      if (resolve_valid) begin
        if (mq.size() == 0) m.err = 1'b1;
        else begin
          h = mq.pop_front();
          if (h.pc != resolve_pc) m.err = 1'b1;
          else hit = 1'b1;
        end
      end
      if (hit) begin
        if (is_branch) m.bc = sat_inc(m.bc);
        if (!is_branch) begin
          if (h.pt) begin rd = 1'b1; npc = h.pc + 64'd4; end
        end else if (h.pm) begin
          if (actual_taken) begin
            m.wbp = 1'b1; m.bsrc = h.pc; m.btgt = actual_target;
            rd = 1'b1; npc = actual_target;
          end
        end else begin
          m.upd = 1'b1; m.src = h.pc; m.dir = actual_taken;
          if (h.pt != actual_taken) begin
            rd = 1'b1; npc = actual_taken ? actual_target : h.pc + 64'd4;
          end else if (actual_taken && h.tgt != actual_target) begin
            m.wbp = 1'b1; m.bsrc = h.pc; m.btgt = actual_target;
            rd = 1'b1; npc = actual_target;
          end
        end
      end
      if (rd) begin
        m.redir = 1'b1; m.rpc = npc; m.mc = sat_inc(m.mc);
        mq.delete();
      end else if (fetch_valid) begin
        if (mq.size() >= QDEPTH) m.err = 1'b1;
        else mq.push_back('{pc: fetch_pc, pt: pred_taken, pm: pred_miss, tgt: pred_target});
      end
      m.full  = (mq.size() == QDEPTH);
      m.empty = (mq.size() == 0);
    end
    e = m;
`ifndef BRANCH_RESOLVER_STATS_EN
    e.bc = '0;
    e.mc = '0;
`endif
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, want, $time);
    end
  endtask

  // Monitor: compare each post-edge output set with the scoreboard entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("write_to_bp",   64'(wbp),      64'(e.wbp));
        chk("branch_source", bsrc,          e.bsrc);
        chk("branch_target", btgt,          e.btgt);
        chk("update_state",  64'(upd),      64'(e.upd));
        chk("source",        src,           e.src);
        chk("actual_taken",  64'(act_dir),  64'(e.dir));
        chk("redirect",      64'(redir),    64'(e.redir));
        chk("redirect_pc",   rpc,           e.rpc);
        chk("full",          64'(full),     64'(e.full));
        chk("empty",         64'(empty),    64'(e.empty));
        chk("sync_error",    64'(sync_err), 64'(e.err));
        chk("branch_count",  64'(bcnt),     64'(e.bc));
        chk("mispred_count", 64'(mcnt),     64'(e.mc));
      end
    end
  end

  task automatic drive(input logic rst, input logic fv, input logic [63:0] fpc,
                       input logic pt, input logic pm, input logic [63:0] ptgt,
                       input logic rv, input logic [63:0] rvpc, input logic br,
                       input logic at, input logic [63:0] atgt, input logic [2:0] st);
    reset = rst; fetch_valid = fv; fetch_pc = fpc; pred_taken = pt; pred_miss = pm;
    pred_target = ptgt; resolve_valid = rv; resolve_pc = rvpc; is_branch = br;
    actual_taken = at; actual_target = atgt;
    st_i = st[0]; st_d = st[1]; st_h = st[2];
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input logic [2:0] st);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, st);
  endtask

  task automatic push(input logic [63:0] pc, input logic pt, input logic pm, input logic [63:0] tgt);
    drive(1'b0, 1'b1, pc, pt, pm, tgt, 1'b0, '0, 1'b0, 1'b0, '0, 3'b000);
  endtask

  task automatic resolve(input logic [63:0] pc, input logic br, input logic at, input logic [63:0] tgt);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, pc, br, at, tgt, 3'b000);
  endtask

  initial begin : stimulus
    logic        fv, pt, pm, rv, br, at, rst;
    logic [63:0] fpc, ptgt, rvpc, atgt;
    logic [2:0]  st;
    int          waits;

    @(negedge clk);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 3'b000);
    idle(3'b000);

    // Cold-miss taken.
    push(64'h1000, 1'b0, 1'b1, '0);
    resolve(64'h1000, 1'b1, 1'b1, 64'h2000);
    // Correct not-taken.
    push(64'h1004, 1'b0, 1'b0, '0);
    resolve(64'h1004, 1'b1, 1'b0, 64'h9999_0000);
    // Target mismatch.
    push(64'h1008, 1'b1, 1'b0, 64'h3000);
    resolve(64'h1008, 1'b1, 1'b1, 64'h3400);
    // Non-branch alias at the top of the address space: pc+4 wraps to 0.
    push(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 64'h4000);
    resolve(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, '0);
    // Stall hold: mispredict then three dcache-stalled cycles with a fetch attempt.
    push(64'h100C, 1'b0, 1'b0, '0);
    resolve(64'h100C, 1'b1, 1'b1, 64'h5000);
    repeat (3) drive(1'b0, 1'b1, 64'h2000, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 3'b010);
    idle(3'b000);
    idle(3'b000);
    // Full, overflow, then flushing resolve with a simultaneous wrong-path push.
    for (int i = 0; i < QDEPTH; i++) push(64'h6000 + 64'(i * 4), 1'b0, 1'b0, '0);
    push(64'h7000, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 64'h7004, 1'b0, 1'b0, '0, 1'b1, 64'h6000, 1'b1, 1'b1, 64'h8000, 3'b000);
    idle(3'b000);
    // Reset mid-operation with five records queued.
    for (int i = 0; i < 5; i++) push(64'hA000 + 64'(i * 4), 1'b0, 1'b1, '0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0, 3'b000);
    idle(3'b000);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      st   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      fv   = $urandom_range(0, 1) == 1;
      fpc  = ($urandom_range(0, 39) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                          : 64'h1000 + {52'd0, 10'($urandom_range(0, 1023)), 2'b00};
      pt   = $urandom_range(0, 1) == 1;
      pm   = $urandom_range(0, 2) == 0;
      ptgt = 64'h8000 + {56'd0, 6'($urandom_range(0, 63)), 2'b00};
      br   = $urandom_range(0, 4) != 0;
      at   = $urandom_range(0, 1) == 1;
      atgt = 64'h8000 + {56'd0, 6'($urandom_range(0, 63)), 2'b00};
      if (mq.size() > 0) begin
        rv   = $urandom_range(0, 1) == 1;
        rvpc = ($urandom_range(0, 59) == 0) ? (mq[0].pc ^ 64'h10) : mq[0].pc;
        if ($urandom_range(0, 1) == 1) atgt = mq[0].tgt;
      end else begin
        rv   = $urandom_range(0, 29) == 0;
        rvpc = fpc;
      end
      drive(rst, fv, fpc, pt, pm, ptgt, rv, rvpc, br, at, atgt, st);
    end
    idle(3'b000);

    waits = 0;
    while (sb.size() != 0 && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage companion to the fetch-stage branch predictor. It queues each fetched instruction's prediction record, checks it against the actual outcome when the instruction resolves, and produces the predictor's allocate and state-update strobes. It also produces the fetch redirect and the wrong-path flush.

## Interface
Parameters:
- QDEPTH, 8: in-flight prediction-record capacity; power of two, 2..32.
- XLEN, 64: PC width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_fetch_valid  in  1  push a prediction record.
- in_fetch_pc  in  XLEN  PC of the fetched instruction.
- in_pred_taken  in  1  predictor's is_branch_taken for that PC.
- in_pred_miss  in  1  predictor's miss (no BTB entry).
- in_pred_target  in  XLEN  predictor's outPc for that PC.
- in_resolve_valid  in  1  the oldest instruction resolves this cycle.
- in_resolve_pc  in  XLEN  PC of the resolving instruction.
- in_is_branch  in  1  the resolving instruction is a conditional branch or jump.
- in_actual_taken  in  1  actual direction.
- in_actual_target  in  XLEN  actual taken target.
- in_stall_from_icache, in_stall_from_dcache, in_stall_from_hazardunit  in  1 each  global stalls.
- out_write_to_bp  out  1  allocate a BTB entry.
- out_branch_source  out  XLEN  allocate PC.
- out_branch_target  out  XLEN  allocate target.
- out_is_update_state  out  1  step the 2-bit counter.
- out_source  out  XLEN  PC whose counter is stepped.
- out_is_actual_branch_taken  out  1  counter direction.
- out_redirect  out  1  fetch must restart.
- out_redirect_pc  out  XLEN  restart PC.
- out_full, out_empty  out  1  queue status.
- out_sync_error  out  1  sticky; set when a resolve has no matching record.
- out_branch_count, out_mispredict_count  out  32 each  statistics (see Configuration).

## Operation
- Stall = OR of the three stall inputs. While stalled:
  - no push, no pop;
  - all outputs hold their values.
- Push: when in_fetch_valid is high and there is no stall, the record {pc, pred_taken, pred_miss, pred_target} is written at the tail.
  - A push while full is dropped and sets out_sync_error.
- Pop: when in_resolve_valid is high and there is no stall, the head record is compared against the resolve inputs, then removed.
  - Resolve while empty, or head.pc != in_resolve_pc, sets out_sync_error and produces no update or redirect.
- Mispredict cases:
  - Non-branch with pred_taken=1 (BTB alias): redirect to pc+4. No update.
  - Branch with pred_miss=1 and actual_taken=1: write_to_bp with (pc, actual_target) and redirect to actual_target.
  - Branch with pred_miss=1 and actual_taken=0: no action.
  - Branch with pred_miss=0: is_update_state with (pc, actual_taken). Redirect if pred_taken != actual_taken; the redirect PC is actual_target if taken, else pc+4.
  - Branch with pred_miss=0, both taken, but pred_target != actual_target: also write_to_bp with the new target and redirect to actual_target.
- Flush: on any redirect, the queue empties at that same edge. A push in the same cycle is discarded as wrong-path.
- pc+4 wraps modulo 2^XLEN.

## Timing
- All outputs are registered, one cycle after the resolve edge.
- Strobes (write_to_bp, is_update_state, redirect) are single-cycle pulses on unstalled cycles.
- A strobe raised or pending during a stall stays high until the first unstalled edge, then clears. The predictor ignores writes while stalled, so it sees the strobe exactly once.
- Push and pop in the same cycle:
  - occupancy is unchanged;
  - allowed when full (the pop frees the slot first);
  - not allowed when empty (the pop is a sync error, the push proceeds).
- Reset values:
  - all strobes, out_sync_error, out_full and both counters are 0;
  - all PC outputs are 0;
  - out_empty is 1;
  - queue pointers are cleared.
- Reset asserted mid-operation discards all in-flight records and any pending strobe.

## Configuration
- BRANCH_RESOLVER_STATS_EN defined:
  - out_branch_count increments on every valid resolved branch;
  - out_mispredict_count increments on every redirect;
  - both are 32-bit saturating, frozen during stall, and cleared by reset.
- Undefined: both counter outputs are driven constant 0 and no counter flops exist.

## Structure
- Shared package branch_pkg:
  - typedef pred_rec_t {pc, pred_taken, pred_miss, pred_target};
  - BTB_INDEX_W=10 and BTB_TAG_W=54 (shared with the predictor);
  - localparam PC_STEP=4.
- Sub-module branch_pred_queue: a circular FIFO of pred_rec_t with QDEPTH entries. It provides push, pop, flush, full and empty, with pointers one bit wider than the index.

## Test plan
- Cold-miss taken: push pc=0x1000 with miss=1, then resolve branch taken to 0x2000. Next cycle: write_to_bp=1, source 0x1000, target 0x2000, redirect to 0x2000, queue empty.
- Correct not-taken: push pc=0x1004 with miss=0, taken=0, then resolve not taken. Next cycle: is_update_state=1, out_source 0x1004, actual_taken=0, no redirect.
- Target mismatch: push pc=0x1008 predicted taken to 0x3000, then resolve taken to 0x3400. Next cycle: is_update_state=1 and write_to_bp=1 with target 0x3400, redirect to 0x3400.
- Stall hold: resolve a mispredict, then assert in_stall_from_dcache for 3 cycles. The redirect stays high for all stalled cycles and clears one cycle after the stall drops.
- Full and flush: push QDEPTH records, then push again. out_full=1 and out_sync_error=1. A subsequent mispredicting resolve empties the queue and discards a simultaneous push.
- Reset mid-operation: with 5 records queued, assert reset for one cycle. out_empty=1 and all strobes and counters are 0.
